// File: rtl/fifo_rd_framer.sv
// Drains a synchronous FIFO into a valid/ready stream framed in BURST_LEN beats.
// Optional parity outputs are compiled in with FRAMER_PARITY_EN.
module fifo_rd_framer #(
  parameter int FIFO_WIDTH = 16,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  drain_en,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FIFO_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [7:0]            frame_cnt,
  output logic                  busy,
  output logic                  err_underflow
`ifdef FRAMER_PARITY_EN
  ,
  output logic                  out_parity,
  output logic                  err_parity_seq
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;
  localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

  logic [1:0] state_reg, state_next;
  logic [7:0] issued_reg, issued_next;
  logic [7:0] beat_reg, beat_next;
  logic [7:0] frame_cnt_reg, frame_cnt_next;
  logic [1:0] occ_reg, occ_next;
  logic       inflight_reg;
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic       err_underflow_reg;

  logic                  pop;
  logic                  last_pop;
  logic                  frame_start;
  logic [1:0]            occ_after_pop;
  logic [FIFO_WIDTH-1:0] head_data;

  // Two-entry ring; each slot is written only when its index matches wr_ptr.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [FIFO_WIDTH-1:0] data_reg;
`ifdef FRAMER_PARITY_EN
      logic                  par_reg;
`endif
      always_ff @(posedge clk) begin
        if (inflight_reg && (wr_ptr_reg == 1'(gi))) begin
          data_reg <= fifo_data_out;
`ifdef FRAMER_PARITY_EN
          par_reg  <= ^fifo_data_out;
`endif
        end
      end
    end
  endgenerate

  assign head_data = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;

  assign out_valid = (occ_reg != 2'd0);
  assign out_data  = out_valid ? head_data : '0;
  assign out_last  = out_valid && (beat_reg == LAST_IDX);
  assign pop       = out_valid && out_ready;
  assign last_pop  = pop && out_last;

  // The slot freed by a same-cycle pop counts as free, which lets a read be
  // issued every cycle while the consumer keeps up.
  assign occ_after_pop = occ_reg - {1'b0, pop};

  assign fifo_rd_en = !fifo_empty
                   && (state_reg == ACTIVE)
                   && ((occ_after_pop + {1'b0, inflight_reg}) < 2'd2)
                   && (issued_reg <= LAST_IDX);

  assign occ_next = occ_after_pop + {1'b0, inflight_reg};

  always_comb begin
    state_next  = state_reg;
    issued_next = issued_reg;
    frame_start = 1'b0;
    case (state_reg)
      IDLE: begin
        if (drain_en && !fifo_empty) begin
          state_next  = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (fifo_rd_en && (issued_reg == LAST_IDX)) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        if (last_pop) begin
          if (drain_en && !fifo_empty) begin
            state_next  = ACTIVE;
            frame_start = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (frame_start) begin
      issued_next = 8'd0;
    end else if (fifo_rd_en) begin
      issued_next = issued_reg + 8'd1;
    end
  end

  always_comb begin
    beat_next      = beat_reg;
    frame_cnt_next = frame_cnt_reg;
    if (pop) begin
      if (out_last) begin
        beat_next      = 8'd0;
        frame_cnt_next = frame_cnt_reg + 8'd1;
      end else begin
        beat_next = beat_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      issued_reg        <= 8'd0;
      beat_reg          <= 8'd0;
      frame_cnt_reg     <= 8'd0;
      occ_reg           <= 2'd0;
      inflight_reg      <= 1'b0;
      wr_ptr_reg        <= 1'b0;
      rd_ptr_reg        <= 1'b0;
      err_underflow_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      issued_reg        <= issued_next;
      beat_reg          <= beat_next;
      frame_cnt_reg     <= frame_cnt_next;
      occ_reg           <= occ_next;
      inflight_reg      <= fifo_rd_en;
      wr_ptr_reg        <= wr_ptr_reg ^ inflight_reg;
      rd_ptr_reg        <= rd_ptr_reg ^ pop;
      err_underflow_reg <= err_underflow_reg | fifo_underflow;
    end
  end

  assign frame_cnt     = frame_cnt_reg;
  assign err_underflow = err_underflow_reg;
  assign busy          = (state_reg != IDLE) || (occ_reg != 2'd0) || inflight_reg;

`ifdef FRAMER_PARITY_EN
  logic head_par;
  logic par_acc_reg;
  logic err_parity_seq_reg;

  assign head_par   = rd_ptr_reg ? g_entry[1].par_reg : g_entry[0].par_reg;
  assign out_parity = out_valid && head_par;

  // Running XOR of beat parities within the current frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_acc_reg        <= 1'b0;
      err_parity_seq_reg <= 1'b0;
    end else if (pop) begin
      if (out_last) begin
        par_acc_reg <= 1'b0;
        if (frame_cnt_reg[0] != (par_acc_reg ^ out_parity)) begin
          err_parity_seq_reg <= 1'b1;
        end
      end else begin
        par_acc_reg <= par_acc_reg ^ out_parity;
      end
    end
  end

  assign err_parity_seq = err_parity_seq_reg;
`endif

endmodule
